// File: rtl/data_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_bus_arbiter_if
//   Bundles the two requesting masters, the shared slave port and the lock
//   timeout flag of the data-side bus arbiter.
//
//   Master 0 / master 1 request side:
//     mX_req_i, mX_addr_i[31:0], mX_wdata_i[31:0], mX_wmask_i[3:0],
//     mX_wen_i (active-low), m1_lock_i
//   Master 0 / master 1 response side:
//     mX_gnt_o, mX_rvalid_o, mX_rdata_o[31:0], mX_err_o
//   Slave side:
//     s_csb_o, s_wen_o, s_addr_o[31:0], s_wdata_o[31:0], s_wmask_o[3:0],
//     s_rdata_i[31:0], s_err_i
//   Status:
//     lock_timeout_o
//
//   Modport "slave" is the arbiter's view: it serves the masters' requests
//   and drives the shared memory port. Modport "master" is the view of
//   everything around the arbiter (requesters plus the memory behind it).
// ---------------------------------------------------------------------------
interface data_bus_arbiter_if;
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic [3:0]  m0_wmask_i;
  logic        m0_wen_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  logic        m0_err_o;

  logic        m1_req_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic [3:0]  m1_wmask_i;
  logic        m1_wen_i;
  logic        m1_lock_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;
  logic        m1_err_o;

  logic        s_csb_o;
  logic        s_wen_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [3:0]  s_wmask_o;
  logic [31:0] s_rdata_i;
  logic        s_err_i;

  logic        lock_timeout_o;

  modport slave (
    input  m0_req_i, m0_addr_i, m0_wdata_i, m0_wmask_i, m0_wen_i,
    input  m1_req_i, m1_addr_i, m1_wdata_i, m1_wmask_i, m1_wen_i, m1_lock_i,
    input  s_rdata_i, s_err_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    output s_csb_o, s_wen_o, s_addr_o, s_wdata_o, s_wmask_o,
    output lock_timeout_o
  );

  modport master (
    output m0_req_i, m0_addr_i, m0_wdata_i, m0_wmask_i, m0_wen_i,
    output m1_req_i, m1_addr_i, m1_wdata_i, m1_wmask_i, m1_wen_i, m1_lock_i,
    output s_rdata_i, s_err_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    input  s_csb_o, s_wen_o, s_addr_o, s_wdata_o, s_wmask_o,
    input  lock_timeout_o
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// ---------------------------------------------------------------------------
// data_bus_arbiter
//   Two-master, one-slave round-robin arbiter for the data-side memory port.
//   Grants are combinational, the response is routed back one cycle after
//   the grant. Master 1 may lock the bus for atomic sequences; the lock is
//   forcibly broken after LOCK_MAX consecutive locked grants so master 0
//   cannot be starved indefinitely.
//
//   Parameters:
//     LOCK_MAX  maximum consecutive locked grant cycles for master 1
//   Ports:
//     clk_i     clock, rising edge
//     reset_i   asynchronous active-low reset
//     bus       data_bus_arbiter_if.slave (masters, slave port, timeout flag)
// ---------------------------------------------------------------------------
module data_bus_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  data_bus_arbiter_if.slave     bus
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_reg, state_next;
  logic             last_gnt_reg, last_gnt_next;
  logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic             rsp_valid_reg;
  logic             rsp_id_reg;

  logic             gnt0, gnt1;
  logic             timeout;
  logic             eff_last;
  logic             arb_idle;

  // -------------------------------------------------------------------------
  // Arbitration and lock FSM (next state plus grant outputs)
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    lock_cnt_next = lock_cnt_reg;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    timeout       = 1'b0;
    eff_last      = last_gnt_reg;
    arb_idle      = 1'b1;

    if (state_reg == LOCKED && bus.m1_req_i && bus.m1_lock_i) begin
      if (lock_cnt_reg == CNT_MAX) begin
        // Lock held too long: arbitrate this cycle as if master 1 had the
        // last grant, so a waiting master 0 wins.
        timeout  = 1'b1;
        eff_last = 1'b1;
      end else begin
        // Still inside the lock budget; the counter only advances below
        // CNT_MAX, so it saturates there and never wraps.
        arb_idle      = 1'b0;
        gnt1          = 1'b1;
        lock_cnt_next = lock_cnt_reg + CNT_ONE;
      end
    end

    // Round-robin arbitration; also covers the cycle in which a lock is
    // released (normally or by timeout).
    if (arb_idle) begin
      state_next    = IDLE;
      lock_cnt_next = '0;
      if (bus.m0_req_i && bus.m1_req_i) begin
        gnt0 = eff_last;
        gnt1 = ~eff_last;
      end else begin
        gnt0 = bus.m0_req_i;
        gnt1 = bus.m1_req_i;
      end
      // A timeout cycle never re-locks; the following IDLE cycle may.
      if (gnt1 && bus.m1_lock_i && !timeout) begin
        state_next    = LOCKED;
        lock_cnt_next = CNT_ONE;
      end
    end

    // No access may be accepted while reset is held.
    if (!reset_i) begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      timeout = 1'b0;
    end

    if (gnt0 || gnt1) begin
      last_gnt_next = gnt1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg     <= IDLE;
      last_gnt_reg  <= 1'b1;
      lock_cnt_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_gnt_reg  <= last_gnt_next;
      lock_cnt_reg  <= lock_cnt_next;
      rsp_valid_reg <= gnt0 | gnt1;
      rsp_id_reg    <= gnt1;
    end
  end

  assign bus.m0_gnt_o       = gnt0;
  assign bus.m1_gnt_o       = gnt1;
  assign bus.lock_timeout_o = timeout;

  // -------------------------------------------------------------------------
  // Slave request mux
  // -------------------------------------------------------------------------
  always_comb begin
    bus.s_wen_o   = 1'b1;
    bus.s_addr_o  = '0;
    bus.s_wdata_o = '0;
    bus.s_wmask_o = '0;
    if (gnt1) begin
      bus.s_wen_o   = bus.m1_wen_i;
      bus.s_addr_o  = bus.m1_addr_i;
      bus.s_wdata_o = bus.m1_wdata_i;
      bus.s_wmask_o = bus.m1_wmask_i;
    end else if (gnt0) begin
      bus.s_wen_o   = bus.m0_wen_i;
      bus.s_addr_o  = bus.m0_addr_i;
      bus.s_wdata_o = bus.m0_wdata_i;
      bus.s_wmask_o = bus.m0_wmask_i;
    end
  end

  assign bus.s_csb_o = ~(gnt0 | gnt1);

  // -------------------------------------------------------------------------
  // Response routing: the owed response goes to the master recorded at grant
  // time; the other master sees zeros.
  // -------------------------------------------------------------------------
  logic [1:0]  rvalid_vec;
  logic [1:0]  err_vec;
  logic [31:0] rdata_vec [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign rvalid_vec[gi] = rsp_valid_reg && (rsp_id_reg == 1'(gi));
    assign err_vec[gi]    = rvalid_vec[gi] & bus.s_err_i;
    assign rdata_vec[gi]  = rvalid_vec[gi] ? bus.s_rdata_i : 32'h0;
  end

  assign bus.m0_rvalid_o = rvalid_vec[0];
  assign bus.m1_rvalid_o = rvalid_vec[1];
  assign bus.m0_err_o    = err_vec[0];
  assign bus.m1_err_o    = err_vec[1];
  assign bus.m0_rdata_o  = rdata_vec[0];
  assign bus.m1_rdata_o  = rdata_vec[1];

endmodule

// File: tb/tb_data_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_bus_arbiter
//   Directed scenarios with literal expectations, followed by a randomized
//   phase. A reference model of the arbitration rules runs alongside and is
//   compared against every DUT output on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_data_bus_arbiter;
  localparam int LM = 4;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  data_bus_arbiter_if bus();

  data_bus_arbiter #(.LOCK_MAX(LM)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int mdl_last   = 1;   // which master was granted most recently
  bit mdl_locked = 0;   // master 1 currently owns the bus
  int mdl_run    = 0;   // consecutive locked grants so far
  bit pend_v     = 0;   // a response is owed this cycle
  int pend_id    = 0;

  task automatic chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Per-cycle compare against the reference model
  // -------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk_i);
      begin
        logic        e_g0, e_g1, e_to, e_rv0, e_rv1, e_er0, e_er1, e_csb, e_wen;
        logic [31:0] e_rd0, e_rd1, e_addr, e_wdata;
        logic [3:0]  e_wmask;
        logic [140:0] exp_v, act_v;
        int g;
        bit to, use_idle;
        int el;

        g = -1; to = 0; use_idle = 1; el = mdl_last;
        if (!reset_i) begin
          mdl_last = 1; mdl_locked = 0; mdl_run = 0; pend_v = 0; pend_id = 0;
          e_rv0 = 0; e_rv1 = 0;
        end else begin
          e_rv0 = pend_v && pend_id == 0;
          e_rv1 = pend_v && pend_id == 1;
          if (mdl_locked && bus.m1_req_i && bus.m1_lock_i) begin
            if (mdl_run >= LM) begin
              to = 1; el = 1;
            end else begin
              g = 1; mdl_run = mdl_run + 1; use_idle = 0;
            end
          end
          if (use_idle) begin
            if (bus.m0_req_i && bus.m1_req_i) g = (el == 1) ? 0 : 1;
            else if (bus.m0_req_i)            g = 0;
            else if (bus.m1_req_i)            g = 1;
            if (g == 1 && bus.m1_lock_i && !to) begin
              mdl_locked = 1; mdl_run = 1;
            end else begin
              mdl_locked = 0; mdl_run = 0;
            end
          end
          if (g >= 0) mdl_last = g;
        end

        e_g0 = (g == 0);
        e_g1 = (g == 1);
        e_to = to;
        e_csb = (g < 0);
        e_rd0 = e_rv0 ? bus.s_rdata_i : 32'h0;
        e_rd1 = e_rv1 ? bus.s_rdata_i : 32'h0;
        e_er0 = e_rv0 & bus.s_err_i;
        e_er1 = e_rv1 & bus.s_err_i;
        if (g == 0) begin
          e_wen = bus.m0_wen_i; e_addr = bus.m0_addr_i;
          e_wdata = bus.m0_wdata_i; e_wmask = bus.m0_wmask_i;
        end else if (g == 1) begin
          e_wen = bus.m1_wen_i; e_addr = bus.m1_addr_i;
          e_wdata = bus.m1_wdata_i; e_wmask = bus.m1_wmask_i;
        end else begin
          e_wen = 1; e_addr = 0; e_wdata = 0; e_wmask = 0;
        end

        exp_v = {e_g0, e_g1, e_to, e_rv0, e_rv1, e_rd0, e_rd1, e_er0, e_er1,
                 e_csb, e_wen, e_addr, e_wdata, e_wmask};
        act_v = {bus.m0_gnt_o, bus.m1_gnt_o, bus.lock_timeout_o,
                 bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m0_rdata_o, bus.m1_rdata_o,
                 bus.m0_err_o, bus.m1_err_o, bus.s_csb_o, bus.s_wen_o,
                 bus.s_addr_o, bus.s_wdata_o, bus.s_wmask_o};
        n_cmp++;
        if (act_v !== exp_v) begin
          n_bad++;
          $display("FAIL model_cycle t=%0t actual=%h expected=%h", $time, act_v, exp_v);
        end

        pend_v  = (g >= 0);
        pend_id = (g == 1) ? 1 : 0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_m0(bit req, bit wen, logic [31:0] a, logic [31:0] d, logic [3:0] m);
    bus.m0_req_i = req; bus.m0_wen_i = wen; bus.m0_addr_i = a;
    bus.m0_wdata_i = d; bus.m0_wmask_i = m;
  endtask

  task automatic set_m1(bit req, bit lk, bit wen, logic [31:0] a, logic [31:0] d, logic [3:0] m);
    bus.m1_req_i = req; bus.m1_lock_i = lk; bus.m1_wen_i = wen; bus.m1_addr_i = a;
    bus.m1_wdata_i = d; bus.m1_wmask_i = m;
  endtask

  initial begin
    logic lk_keep;
    bus.s_rdata_i = 32'h0;
    bus.s_err_i   = 1'b0;
    set_m0(1, 1, 32'h100, 32'h0, 4'h0);
    set_m1(1, 0, 1, 32'h200, 32'h0, 4'h0);

    // Reset holds grants off even with both requesting
    @(negedge clk_i);
    chk1("rst_gnt0", bus.m0_gnt_o, 1'b0);
    chk1("rst_gnt1", bus.m1_gnt_o, 1'b0);
    chk1("rst_csb", bus.s_csb_o, 1'b1);
    chk1("rst_wen", bus.s_wen_o, 1'b1);
    chk1("rst_rvalid0", bus.m0_rvalid_o, 1'b0);

    // Release: master 0 wins first, then strict alternation
    cyc(); reset_i = 1'b1;
    @(negedge clk_i);
    chk1("rr0_gnt0", bus.m0_gnt_o, 1'b1);
    chk1("rr0_gnt1", bus.m1_gnt_o, 1'b0);
    for (int i = 1; i < 6; i++) begin
      cyc();
      @(negedge clk_i);
      chk1("rr_gnt0", bus.m0_gnt_o, (i % 2) == 0);
      chk1("rr_gnt1", bus.m1_gnt_o, (i % 2) == 1);
      chk1("rr_rvalid0", bus.m0_rvalid_o, ((i - 1) % 2) == 0);
      chk1("rr_rvalid1", bus.m1_rvalid_o, ((i - 1) % 2) == 1);
    end

    // Read routing to master 1
    cyc();
    set_m0(0, 1, 32'h0, 32'h0, 4'h0);
    set_m1(1, 0, 1, 32'h1E04, 32'h0, 4'h0);
    @(negedge clk_i);
    chk1("rd_gnt1", bus.m1_gnt_o, 1'b1);
    chk32("rd_addr", bus.s_addr_o, 32'h1E04);
    chk1("rd_csb", bus.s_csb_o, 1'b0);
    cyc();
    set_m1(0, 0, 1, 32'h0, 32'h0, 4'h0);
    bus.s_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    chk1("rd_rvalid1", bus.m1_rvalid_o, 1'b1);
    chk32("rd_rdata1", bus.m1_rdata_o, 32'hDEADBEEF);
    chk1("rd_rvalid0", bus.m0_rvalid_o, 1'b0);
    chk32("rd_rdata0", bus.m0_rdata_o, 32'h0);

    // Write passthrough from master 0
    cyc();
    set_m0(1, 0, 32'h1E00, 32'h12345678, 4'b0011);
    @(negedge clk_i);
    chk1("wr_gnt0", bus.m0_gnt_o, 1'b1);
    chk1("wr_wen", bus.s_wen_o, 1'b0);
    chk32("wr_mask", 32'(bus.s_wmask_o), 32'h3);
    chk32("wr_addr", bus.s_addr_o, 32'h1E00);
    chk32("wr_wdata", bus.s_wdata_o, 32'h12345678);
    cyc();
    set_m0(0, 1, 32'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    chk1("wr_rvalid0", bus.m0_rvalid_o, 1'b1);
    chk1("wr_rvalid1", bus.m1_rvalid_o, 1'b0);

    // Lock with timeout: m1 holds 4 cycles, then m0 wins on the timeout cycle
    cyc();
    set_m0(1, 1, 32'h40, 32'h0, 4'h0);
    set_m1(1, 1, 1, 32'h80, 32'h0, 4'h0);
    @(negedge clk_i);
    chk1("lk1_gnt1", bus.m1_gnt_o, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      cyc();
      @(negedge clk_i);
      chk1("lk_gnt1", bus.m1_gnt_o, 1'b1);
      chk1("lk_gnt0", bus.m0_gnt_o, 1'b0);
      chk1("lk_to", bus.lock_timeout_o, 1'b0);
    end
    cyc();
    @(negedge clk_i);
    chk1("to_pulse", bus.lock_timeout_o, 1'b1);
    chk1("to_gnt0", bus.m0_gnt_o, 1'b1);
    chk1("to_gnt1", bus.m1_gnt_o, 1'b0);
    cyc();
    @(negedge clk_i);
    chk1("relock_gnt1", bus.m1_gnt_o, 1'b1);
    chk1("relock_to", bus.lock_timeout_o, 1'b0);
    cyc();
    @(negedge clk_i);
    chk1("relock_hold_gnt1", bus.m1_gnt_o, 1'b1);
    chk1("relock_hold_gnt0", bus.m0_gnt_o, 1'b0);

    // Error response on a master 0 access
    cyc();
    set_m0(0, 1, 32'h0, 32'h0, 4'h0);
    set_m1(0, 0, 1, 32'h0, 32'h0, 4'h0);
    cyc();
    set_m0(1, 1, 32'h44, 32'h0, 4'h0);
    @(negedge clk_i);
    chk1("err_gnt0", bus.m0_gnt_o, 1'b1);
    cyc();
    set_m0(0, 1, 32'h0, 32'h0, 4'h0);
    bus.s_err_i = 1'b1;
    bus.s_rdata_i = 32'h0BAD0BAD;
    @(negedge clk_i);
    chk1("err_err0", bus.m0_err_o, 1'b1);
    chk1("err_rvalid0", bus.m0_rvalid_o, 1'b1);
    chk1("err_err1", bus.m1_err_o, 1'b0);

    // Reset right after a grant discards the owed response
    cyc();
    bus.s_err_i = 1'b0;
    set_m0(1, 1, 32'h48, 32'h0, 4'h0);
    @(negedge clk_i);
    chk1("mid_gnt0", bus.m0_gnt_o, 1'b1);
    cyc();
    reset_i = 1'b0;
    set_m0(0, 1, 32'h0, 32'h0, 4'h0);
    set_m1(1, 0, 1, 32'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    chk1("mid_rvalid0", bus.m0_rvalid_o, 1'b0);
    chk1("mid_gnt1", bus.m1_gnt_o, 1'b0);
    cyc();
    reset_i = 1'b1;

    // Randomized phase; lock request is sticky to reach the timeout often
    lk_keep = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset_i = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 99) < 15) lk_keep = ~lk_keep;
      set_m0($urandom_range(0, 99) < 65, 1'($urandom), $urandom, $urandom, 4'($urandom));
      set_m1($urandom_range(0, 99) < 75, lk_keep, 1'($urandom), $urandom, $urandom, 4'($urandom));
      bus.s_rdata_i = $urandom;
      bus.s_err_i   = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master, one-slave arbiter for the data-side memory port. It shares memory port 0 and the peripheral address space between the core's data interface (master 0) and a secondary bus master (master 1, e.g. a loader or DMA engine). Request and grant are combinational, the response is routed one cycle later, and arbitration is round-robin. Master 1 can lock the bus for short atomic sequences; a lock timeout bounds how long master 0 can be starved.

## Interface
- LOCK_MAX, default 16: maximum consecutive locked grant cycles for master 1 before the lock is forcibly broken.
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous active-low reset.
- m0_req_i, m1_req_i  input  1  access request.
- m0_addr_i, m1_addr_i  input  32  byte address.
- m0_wdata_i, m1_wdata_i  input  32  write data.
- m0_wmask_i, m1_wmask_i  input  4  byte write mask.
- m0_wen_i, m1_wen_i  input  1  active-low write enable (0 = write).
- m1_lock_i  input  1  master 1 requests exclusive ownership.
- m0_gnt_o, m1_gnt_o  output  1  combinational grant; the access is accepted in this cycle.
- m0_rvalid_o, m1_rvalid_o  output  1  response valid, one cycle after the grant.
- m0_rdata_o, m1_rdata_o  output  32  read data; valid while rvalid is high.
- m0_err_o, m1_err_o  output  1  error response, qualified by rvalid.
- s_csb_o  output  1  active-low slave chip select.
- s_wen_o  output  1  active-low slave write enable.
- s_addr_o  output  32  slave address.
- s_wdata_o  output  32  slave write data.
- s_wmask_o  output  4  slave write mask.
- s_rdata_i  input  32  slave read data, one cycle after select.
- s_err_i  input  1  slave error, same cycle as s_rdata_i.
- lock_timeout_o  output  1  one-cycle pulse when a lock is forcibly broken.

## Operation
- Registered state:
  - last_gnt: 1 bit; 0 means master 0 was granted last.
  - rsp_valid, rsp_id: track the response that is owed.
  - FSM with states IDLE and LOCKED.
  - lock_cnt: width $clog2(LOCK_MAX+1).
- Grant in IDLE:
  - One requester: that master is granted.
  - Both requesting: the master not equal to last_gnt is granted.
  - last_gnt updates only on a cycle with a grant.
- Transition IDLE -> LOCKED: m1 is granted with m1_lock_i=1. lock_cnt is set to 1.
- Grant in LOCKED:
  - Only master 1 can be granted; m0_gnt_o=0 even when m0_req_i=1.
  - lock_cnt increments on each cycle master 1 is granted.
- Transition LOCKED -> IDLE:
  - Normal exit: m1_lock_i=0 or m1_req_i=0. This is evaluated combinationally, so grant in that cycle follows IDLE rules.
  - Timeout exit: lock_cnt==LOCK_MAX with m1_lock_i still high. lock_timeout_o pulses, that cycle is arbitrated as IDLE with last_gnt forced to 1, so master 0 wins if requesting. The next IDLE cycle may re-lock.
- Slave mux:
  - s_* fields mirror the granted master.
  - s_csb_o = ~(m0_gnt_o|m1_gnt_o).
  - With no grant: s_wen_o=1, s_wmask_o=0, s_addr_o=0, s_wdata_o=0.
- Response routing:
  - rsp_valid <= any grant; rsp_id <= granted index.
  - mX_rvalid_o = rsp_valid & (rsp_id==X).
  - rdata and err pass s_rdata_i and s_err_i to the selected master; the other master's outputs are 0.
  - Writes also produce rvalid as a write acknowledgement.
- Back-to-back grants every cycle are legal; the response pipeline is one deep and never stalls.

## Timing
- Reset values (asynchronous, on reset_i low):
  - gnt=0, rvalid=0, rdata=0, err=0, lock_timeout_o=0.
  - s_csb_o=1, s_wen_o=1.
  - state=IDLE, last_gnt=1, lock_cnt=0, rsp_valid=0.
- While reset_i=0, grants are forced to 0 regardless of requests.
- Grant latency is 0 cycles; response latency is exactly 1 cycle after the grant.
- Reset mid-transaction discards the pending response: rvalid is never raised for a request granted in the cycle reset asserts.
- A master must hold its request fields stable only in the cycle it is granted. A dropped request that was not granted has no side effects.
- lock_cnt saturates at LOCK_MAX and never wraps.

## Test plan
- Reset: reset_i=0 with both requests high -> both gnt=0, s_csb_o=1. First cycle after release with both requesting -> m0_gnt_o=1.
- Round-robin: both masters request continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1. Each rvalid follows its grant by 1 cycle.
- Read routing: m1 reads addr 0x1E04 with s_rdata_i=0xDEADBEEF the next cycle -> m1_rvalid_o=1, m1_rdata_o=0xDEADBEEF, m0_rvalid_o=0, m0_rdata_o=0.
- Write passthrough: m0 writes 0x12345678 with wmask=4'b0011 at 0x1E00 -> s_wen_o=0, s_wmask_o=4'b0011, s_addr_o=0x1E00 in the grant cycle. m0_rvalid_o=1 in the next cycle.
- Lock timeout (LOCK_MAX=4): m1 requests with lock while m0 requests continuously -> m1 granted 4 cycles, then lock_timeout_o pulses and m0 is granted that cycle. m1 can re-lock the following cycle.
- Error: s_err_i=1 in the response cycle of an m0 access -> m0_err_o=1 with m0_rvalid_o=1, m1_err_o=0.
